instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Pipeline stage 1 of the five-stage MIPS core, directly upstream of instruction decode. Holds the PC and a word-addressed instruction memory that the debug unit loads while the core is halted. Drives the IF/ID pipeline register (instruction plus PC+4) and accepts jump/branch redirects resolved in ID. Freezes on stall and halt, and stops fetching once the end-of-program word is fetched.

Parameters:
MEM_DEPTH_WORDS, 256, instruction memory depth in 32-bit words (power of two).
MEM_ADDR_WIDTH, 8, log2(MEM_DEPTH_WORDS).

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_jump  in  1  redirect request from ID (combinational in ID)
i_jump_address  in  32  byte address of redirect target
i_stall  in  1  hazard unit load-use stall; hold PC and IF/ID
i_halt  in  1  debug halt; freeze the stage completely
i_inst_write_enable  in  1  debug unit instruction-memory write strobe
i_inst_write_addr  in  32  byte address of write; bits [1:0] ignored
i_inst_write_data  in  32  instruction word to write
o_instruction  out  32  IF/ID register: fetched instruction
o_pc  out  32  IF/ID register: address of o_instruction + 4
o_current_pc  out  32  live PC, for debug unit
o_fetch_done  out  1  high once END word fetched (state DONE)

Behaviour:
- Reset value of async reset (any time, including mid-run): PC=0, o_instruction=32'h00000000 (NOP), o_pc=0, o_fetch_done=0, state=RUN. Memory contents are not cleared by reset.
- Memory: synchronous write on i_clk when i_inst_write_enable; index = i_inst_write_addr[MEM_ADDR_WIDTH+1:2]. Asynchronous read at index PC[MEM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo depth. A write to the word being read becomes visible in the next cycle. Writes are honoured in every state, including halt and DONE.
- Fetch latency: one cycle. The word at PC appears on o_instruction after the next edge, with o_pc = PC+4 (32-bit wrap).
- FSM states: RUN and DONE.
- RUN, per edge, in priority order:
  1. i_halt: PC and IF/ID hold.
  2. i_stall: PC and IF/ID hold. i_jump in the same cycle is ignored, because ID re-evaluates the jump after the stall.
  3. Fetched word == 32'hFFFFFFFF: IF/ID latches the END word and PC+4. PC holds. Go to DONE. END wins over a simultaneous i_jump.
  4. Otherwise IF/ID latches the fetched word and PC+4.
     - PC <= i_jump ? i_jump_address : PC+4.
     - The instruction fetched in the jump cycle is not flushed (branch delay slot). This matches ID producing a return address of PC+8 for JAL/JALR.
- DONE:
  - PC, o_instruction (END) and o_pc hold.
  - o_fetch_done=1.
  - i_jump and i_stall are ignored.
  - Exit is by reset only.
- i_jump_address[1:0] ≠ 0: loaded unchanged; the read uses word index only.
- o_fetch_done is registered and equal to (state==DONE).

Decomposition:
- Shared package: NOP and END_INSTR constants (32'h00000000, 32'hFFFFFFFF), plus a fetch state enum (RUN, DONE). The decode stage uses the same constants.
- One sub-module, instruction_memory: parameterised depth, sync write, async read. The PC, FSM and IF/ID register stay in instruction_fetch.

Test Plan:
1. Sequential fetch: load words 0x20010005, 0x20020007, 0x00221820 at 0x0/0x4/0x8, then release reset. Required: o_instruction shows them on consecutive cycles with o_pc = 0x4, 0x8, 0xC.
2. Stall: assert i_stall for 2 cycles while PC=0x8. Required: PC stays 0x8, o_instruction/o_pc unchanged for 2 cycles, then the fetch at 0x8 proceeds. Assert i_jump during the stall: no effect.
3. Jump with delay slot: i_jump=1, i_jump_address=0x40 while PC=0x10. Required:
   - next o_instruction = mem[0x10], o_pc = 0x14;
   - the following cycle o_instruction = mem[0x40], o_pc = 0x44.
4. END: place 0xFFFFFFFF at 0x0C. Required:
   - after the fetch, o_instruction = 0xFFFFFFFF, o_fetch_done = 1, PC = 0x0C;
   - all three hold for 10 cycles even with i_jump pulsed.
5. Halt + load: set i_halt=1 at PC=0x8 and write 0x12345678 to 0x8. Required: outputs frozen during halt; after release, o_instruction = 0x12345678.
6. Reset mid-run: assert i_reset between clock edges at PC=0x24. Required:
   - o_instruction = 0, o_pc = 0, o_current_pc = 0, o_fetch_done = 0 immediately, without a clock edge;
   - memory contents intact; fetch restarts at 0x0.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch/decode constants and fetch state enum
package instruction_fetch_pkg;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam logic [31:0] END_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - word-addressed instruction store, sync write, async read
module instruction_memory #(
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_write_enable,
  input  logic [ADDR_WIDTH-1:0] i_write_index,
  input  logic [31:0]           i_write_data,
  input  logic [ADDR_WIDTH-1:0] i_read_index,
  output logic [31:0]           o_read_data
);

  // Deliberately not reset: the debug unit's program must survive a core reset.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_write_enable) begin
      mem[i_write_index] <= i_write_data;
    end
  end

  assign o_read_data = mem[i_read_index];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, instruction memory, IF/ID register, END detection
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 256,
  parameter int MEM_ADDR_WIDTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_jump,
  input  logic [31:0] i_jump_address,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_inst_write_enable,
  input  logic [31:0] i_inst_write_addr,
  input  logic [31:0] i_inst_write_data,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_current_pc,
  output logic        o_fetch_done
);

  fetch_state_t state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  ifid_instruction, ifid_instruction_next;
  logic [31:0]  ifid_pc, ifid_pc_next;
  logic [31:0]  fetched;
  logic [31:0]  pc_plus4;
  logic         unused_write_addr_bits;

  assign pc_plus4 = pc + 32'd4;

  // Byte offset and out-of-range bits fold away: addresses wrap modulo depth.
  assign unused_write_addr_bits = ^{i_inst_write_addr[31:MEM_ADDR_WIDTH+2],
                                    i_inst_write_addr[1:0]};

  instruction_memory #(
    .DEPTH      (MEM_DEPTH_WORDS),
    .ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_imem (
    .i_clk          (i_clk),
    .i_write_enable (i_inst_write_enable),
    .i_write_index  (i_inst_write_addr[MEM_ADDR_WIDTH+1:2]),
    .i_write_data   (i_inst_write_data),
    .i_read_index   (pc[MEM_ADDR_WIDTH+1:2]),
    .o_read_data    (fetched)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state            <= RUN;
      pc               <= '0;
      ifid_instruction <= NOP;
      ifid_pc          <= '0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      ifid_instruction <= ifid_instruction_next;
      ifid_pc          <= ifid_pc_next;
    end
  end

  always_comb begin
    state_next            = state;
    pc_next               = pc;
    ifid_instruction_next = ifid_instruction;
    ifid_pc_next          = ifid_pc;
    case (state)
      RUN: begin
        // A stalled jump is dropped; ID presents it again once the stall clears.
        if (!i_halt && !i_stall) begin
          ifid_instruction_next = fetched;
          ifid_pc_next          = pc_plus4;
          if (fetched == END_INSTR) begin
            state_next = DONE;
          end else if (i_jump) begin
            pc_next = i_jump_address;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      DONE: begin
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  assign o_instruction = ifid_instruction;
  assign o_pc          = ifid_pc;
  assign o_current_pc  = pc;
  assign o_fetch_done  = (state == DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench: directed vector table plus randomized model compare
module tb_instruction_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_address = '0;
  logic        i_stall = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_inst_write_enable = 1'b0;
  logic [31:0] i_inst_write_addr = '0;
  logic [31:0] i_inst_write_data = '0;
  logic [31:0] o_instruction, o_pc, o_current_pc;
  logic        o_fetch_done;

  int pass_count = 0;
  int total_count = 0;

  instruction_fetch #(
    .MEM_DEPTH_WORDS (256),
    .MEM_ADDR_WIDTH  (8)
  ) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_jump              (i_jump),
    .i_jump_address      (i_jump_address),
    .i_stall             (i_stall),
    .i_halt              (i_halt),
    .i_inst_write_enable (i_inst_write_enable),
    .i_inst_write_addr   (i_inst_write_addr),
    .i_inst_write_data   (i_inst_write_data),
    .o_instruction       (o_instruction),
    .o_pc                (o_pc),
    .o_current_pc        (o_current_pc),
    .o_fetch_done        (o_fetch_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        halt;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_cur;
    logic        e_done;
  } vec_t;

  vec_t vecs[17];

  logic [31:0] mem_m [256];
  logic [31:0] pc_m, inst_m, opc_m;
  logic        done_m;

  function automatic vec_t mk(logic h, logic s, logic j, logic [31:0] ja,
                              logic we, logic [31:0] wa, logic [31:0] wd,
                              logic [31:0] ei, logic [31:0] ep, logic [31:0] ec,
                              logic ed);
    vec_t v;
    v.halt = h; v.stall = s; v.jump = j; v.jaddr = ja;
    v.we = we; v.waddr = wa; v.wdata = wd;
    v.e_inst = ei; v.e_pc = ep; v.e_cur = ec; v.e_done = ed;
    return v;
  endfunction

  function automatic logic [31:0] init_word(int i);
    case (i)
      0:       return 32'h2001_0005;
      1:       return 32'h2002_0007;
      2:       return 32'h0022_1820;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_jump = 1'b0; i_jump_address = '0; i_stall = 1'b0; i_halt = 1'b0;
    i_inst_write_enable = 1'b0; i_inst_write_addr = '0; i_inst_write_data = '0;
  endtask

  task automatic check_outputs(string tag, logic [31:0] ei, logic [31:0] ep,
                               logic [31:0] ec, logic ed);
    check({tag, "_inst"}, o_instruction, ei);
    check({tag, "_pc"}, o_pc, ep);
    check({tag, "_cur"}, o_current_pc, ec);
    check({tag, "_done"}, {31'b0, o_fetch_done}, {31'b0, ed});
  endtask

  // Reference: one clock edge of the fetch stage computed straight from the rules.
  task automatic model_step(logic rst, logic h, logic s, logic j, logic [31:0] ja,
                            logic we, logic [31:0] wa, logic [31:0] wd);
    logic [31:0] word;
    word = mem_m[pc_m[9:2]];
    if (rst) begin
      pc_m = '0; inst_m = '0; opc_m = '0; done_m = 1'b0;
    end else if (!done_m && !h && !s) begin
      inst_m = word;
      opc_m  = pc_m + 32'd4;
      if (word == 32'hFFFF_FFFF) done_m = 1'b1;
      else pc_m = j ? ja : pc_m + 32'd4;
    end
    if (we) mem_m[wa[9:2]] = wd;
  endtask

  initial begin
    // Preload the program while reset is held.
    for (int i = 0; i < 256; i++) begin
      i_inst_write_enable = 1'b1;
      i_inst_write_addr = 32'(i) * 4;
      i_inst_write_data = init_word(i);
      cycle();
    end
    clear_inputs();
    check_outputs("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    //             h  s  j  jaddr     we wa     wd            inst          pc     cur    done
    vecs[0]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h2001_0005, 32'h04, 32'h04, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h2002_0007, 32'h08, 32'h08, 0);
    vecs[2]  = mk(0, 1, 1, 32'h80,   0, 32'h0, 32'h0,        32'h2002_0007, 32'h08, 32'h08, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0,    0, 32'h0, 32'h0,        32'h2002_0007, 32'h08, 32'h08, 0);
    vecs[4]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h0022_1820, 32'h0C, 32'h0C, 0);
    vecs[5]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h1000_0003, 32'h10, 32'h10, 0);
    vecs[6]  = mk(0, 0, 1, 32'h40,   0, 32'h0, 32'h0,        32'h1000_0004, 32'h14, 32'h40, 0);
    vecs[7]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h1000_0010, 32'h44, 32'h44, 0);
    vecs[8]  = mk(0, 0, 1, 32'h0B,   0, 32'h0, 32'h0,        32'h1000_0011, 32'h48, 32'h0B, 0);
    vecs[9]  = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h0022_1820, 32'h0F, 32'h0F, 0);
    vecs[10] = mk(1, 0, 1, 32'h80,   1, 32'h0C, 32'h1234_5678, 32'h0022_1820, 32'h0F, 32'h0F, 0);
    vecs[11] = mk(1, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h0022_1820, 32'h0F, 32'h0F, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,    0, 32'h0, 32'h0,        32'h1234_5678, 32'h13, 32'h13, 0);
    vecs[13] = mk(0, 0, 1, 32'h14,   1, 32'h14, 32'hFFFF_FFFF, 32'h1000_0004, 32'h17, 32'h14, 0);
    vecs[14] = mk(0, 0, 1, 32'h200,  0, 32'h0, 32'h0,        32'hFFFF_FFFF, 32'h18, 32'h14, 1);
    vecs[15] = mk(0, 0, 1, 32'h0,    0, 32'h0, 32'h0,        32'hFFFF_FFFF, 32'h18, 32'h14, 1);
    vecs[16] = mk(0, 1, 0, 32'h0,    0, 32'h0, 32'h0,        32'hFFFF_FFFF, 32'h18, 32'h14, 1);

    i_reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      i_halt = vecs[k].halt; i_stall = vecs[k].stall;
      i_jump = vecs[k].jump; i_jump_address = vecs[k].jaddr;
      i_inst_write_enable = vecs[k].we; i_inst_write_addr = vecs[k].waddr;
      i_inst_write_data = vecs[k].wdata;
      cycle();
      check_outputs($sformatf("vec%0d", k), vecs[k].e_inst, vecs[k].e_pc,
                    vecs[k].e_cur, vecs[k].e_done);
    end
    clear_inputs();

    // DONE is sticky against jump and stall.
    for (int k = 0; k < 10; k++) begin
      i_jump = 1'($urandom_range(0, 1));
      i_jump_address = $urandom();
      i_stall = 1'($urandom_range(0, 1));
      cycle();
      check_outputs("done_hold", 32'hFFFF_FFFF, 32'h18, 32'h14, 1'b1);
    end
    clear_inputs();

    // Asynchronous reset mid-run at PC=0x24; memory survives.
    i_reset = 1'b1;
    i_inst_write_enable = 1'b1; i_inst_write_addr = 32'h14; i_inst_write_data = 32'h1000_0005;
    cycle();
    clear_inputs();
    i_reset = 1'b0;
    repeat (9) cycle();
    check("pre_reset_cur", o_current_pc, 32'h24);
    #3;
    i_reset = 1'b1;
    #1;
    check_outputs("async_reset", 32'h0, 32'h0, 32'h0, 1'b0);
    i_reset = 1'b0;
    cycle();
    check("restart_inst", o_instruction, 32'h2001_0005);
    check("restart_pc", o_pc, 32'h04);

    // Randomized run against the reference model.
    i_reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom();
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      i_inst_write_enable = 1'b1;
      i_inst_write_addr = 32'(i) * 4;
      i_inst_write_data = w;
      mem_m[i] = w;
      cycle();
    end
    clear_inputs();
    pc_m = '0; inst_m = '0; opc_m = '0; done_m = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      i_reset = r;
      i_halt = ($urandom_range(0, 7) == 0);
      i_stall = ($urandom_range(0, 7) == 0);
      i_jump = ($urandom_range(0, 3) == 0);
      i_jump_address = $urandom();
      i_inst_write_enable = ($urandom_range(0, 3) == 0);
      i_inst_write_addr = $urandom();
      i_inst_write_data = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      cycle();
      model_step(r, i_halt, i_stall, i_jump, i_jump_address,
                 i_inst_write_enable, i_inst_write_addr, i_inst_write_data);
      check("rand_inst", o_instruction, inst_m);
      check("rand_pc", o_pc, opc_m);
      check("rand_cur", o_current_pc, pc_m);
      check("rand_done", {31'b0, o_fetch_done}, {31'b0, done_m});
    end
    clear_inputs();
    i_reset = 1'b0;

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
